fetch_prefetch_queue: RTL and testbench

- Instruction-fetch front end that sits directly upstream of the IF/ID register stage.
- Issues sequential word fetches to instruction memory (variable latency, in-order responses) and buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- Presents one instruction per cycle to decode via valid/ready; ready is driven by the pipeline write enable (stall = not ready).
- Redirects (branch/jump taken, flush) restart fetch at a new PC and discard all stale data, including responses still in flight.

---
 rtl/fetch_prefetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher feeding decode through a DEPTH-entry FIFO; FETCH_BYPASS_EN adds a response-to-decode bypass.
// Latency: memory response to out_valid is 1 cycle (0 cycles with FETCH_BYPASS_EN defined).
// Backpressure: out_ready low holds the head; issue stops while entries + outstanding requests reach DEPTH.
module fetch_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    input  logic            out_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];

    logic [CW:0]     occupancy;
    logic [XLEN-1:0] redirect_pc_al;
    logic            issue, resp_acc, resp_keep, push, pop, fifo_vld;

    // Low two bits of the redirect target are masked off (word-aligned fetch).
    assign redirect_pc_al = redirect_pc & ~XLEN'(3);
    assign occupancy      = {1'b0, count_q} + {1'b0, outst_q};
    assign mem_req        = !rst && !redirect && (occupancy < (CW+1)'(DEPTH));
    assign mem_addr       = fetch_pc_q;
    assign issue          = mem_req && mem_gnt;
    // Responses with nothing outstanding are strays (e.g. after reset) and are ignored.
    assign resp_acc       = mem_rvalid && (outst_q != '0);
    // Stale responses (drop_q != 0) and any response landing on a redirect are discarded.
    assign resp_keep      = resp_acc && (drop_q == '0) && !redirect;
    assign fifo_vld       = (count_q != '0);
    assign pop            = fifo_vld && out_ready && !redirect;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    // Empty queue: a kept response is shown to decode in the same cycle it arrives.
    assign bypass    = resp_keep && !fifo_vld;
    assign out_valid = !rst && (fifo_vld || bypass);
    assign out_inst  = fifo_vld ? inst_mem_q[rd_ptr_q] : mem_rdata;
    assign out_pc    = fifo_vld ? pc_mem_q[rd_ptr_q]   : resp_pc_q;
    // A bypassed word taken by decode never enters the FIFO.
    assign push      = resp_keep && !(bypass && out_ready);
`else
    assign out_valid = !rst && fifo_vld;
    assign out_inst  = inst_mem_q[rd_ptr_q];
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign push      = resp_keep;
`endif

    // Next-state for fetch/response PCs, counters and FIFO pointers; redirect overrides push/pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        outst_d    = outst_q + CW'(issue) - CW'(resp_acc);
        if (redirect) begin
            fetch_pc_d = redirect_pc_al;
            resp_pc_d  = redirect_pc_al;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            // Everything still in flight after this cycle belongs to the old path.
            drop_d     = outst_d;
        end else begin
            if (issue)
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (resp_keep)
                resp_pc_d = resp_pc_q + XLEN'(4);
            if (resp_acc && (drop_q != '0))
                drop_d = drop_q - CW'(1);
            if (push)
                wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // State registers with synchronous reset taking priority over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset since count_q qualifies every read.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[wr_ptr_q] <= mem_rdata;
            pc_mem_q[wr_ptr_q]   <= resp_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
module tb_fetch_prefetch_queue;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
    localparam int EXP_LAT = 2;
`else
    localparam int EXP_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;

    fetch_prefetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          lat      = 1;
    int          ngrants  = 0;
    int          npops    = 0;
    bit          gnt_en   = 1'b1;
    bit          nop_mode = 1'b1;
    bit          seen_valid;
    bit          saw_zero;
    logic [31:0] exp_fetch = RESET_PC;
    logic [31:0] first_gnt_addr;
    logic [31:0] first_pop_pc;
    logic [31:0] exp_pc[$];
    logic [31:0] exp_inst[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    // Memory contents: nop everywhere, or an address-derived pattern.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return nop_mode ? 32'h0000_0013 : ((a ^ 32'hC0DE_0000) + 32'h1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1 ns later, update the model, advance.
    task automatic tick(input bit rd, input logic [31:0] rpc, input bit rdy, input bit stray);
        bit deliver;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
        mem_gnt     = gnt_en;
        deliver     = (pend_addr.size() != 0) && (pend_due[0] <= cyc);
        if (deliver) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mdata(pend_addr[0]);
        end else if (stray) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        #1;
        seen_valid = out_valid;
        if (rst || rd)
            chk("req_blocked", 32'(mem_req), 32'd0);
        if (rst)
            chk("rst_out_valid", 32'(out_valid), 32'd0);
        if (mem_req && mem_gnt) begin
            chk("mem_addr", mem_addr, exp_fetch);
            if (ngrants == 0)
                first_gnt_addr = mem_addr;
            ngrants++;
            pend_addr.push_back(mem_addr);
            pend_due.push_back(cyc + lat);
            exp_pc.push_back(exp_fetch);
            exp_inst.push_back(mdata(exp_fetch));
            exp_fetch += 32'd4;
        end
        if (deliver) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (!rst && !rd && out_valid && out_ready) begin
            chk("pop_expected", 32'(exp_pc.size() != 0), 32'd1);
            if (exp_pc.size() != 0) begin
                chk("out_pc", out_pc, exp_pc[0]);
                chk("out_inst", out_inst, exp_inst[0]);
                if (npops == 0)
                    first_pop_pc = out_pc;
                if (out_pc == 32'h0)
                    saw_zero = 1'b1;
                npops++;
                void'(exp_pc.pop_front());
                void'(exp_inst.pop_front());
            end
        end
        if (rst) begin
            exp_pc.delete();
            exp_inst.delete();
            pend_addr.delete();
            pend_due.delete();
            exp_fetch = RESET_PC;
        end else if (rd) begin
            exp_pc.delete();
            exp_inst.delete();
            exp_fetch = rpc & ~32'h3;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++)
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        rst      = 1'b0;
        ngrants  = 0;
        npops    = 0;
        saw_zero = 1'b0;
    endtask

    initial begin
        int first;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; mem_gnt = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = 32'h0; out_ready = 1'b0;
        @(negedge clk);

        // Streaming nops with 1-cycle memory and decode always ready.
        do_reset(2);
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b0);
            if (seen_valid && first == 0)
                first = i;
        end
        chk("first_valid_cycle", 32'(first), 32'(EXP_LAT));
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b0);
            chk("sustained_valid", 32'(seen_valid), 32'd1);
        end

        // Decode stalled: queue fills to DEPTH and issue stops, then drains.
        do_reset(2);
        for (int i = 0; i < 10; i++)
            tick(1'b0, 32'h0, 1'b0, 1'b0);
        chk("full_grants", 32'(ngrants), 32'd4);
        chk("full_req_low", 32'(mem_req), 32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
        chk("full_head_pc", out_pc, 32'h0);
        ngrants = 0;
        npops   = 0;
        for (int i = 0; i < 4; i++)
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_pops", 32'(npops), 32'd4);
        chk("resume_addr", first_gnt_addr, 32'h10);

        // Redirect with two requests in flight at latency 3.
        nop_mode = 1'b0;
        lat      = 3;
        do_reset(2);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        chk("inflight", 32'(ngrants), 32'd2);
        ngrants = 0;
        npops   = 0;
        tick(1'b1, 32'h0000_0103, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'h0, 1'b1, 1'b0);
            chk("stale_dropped_valid", 32'(seen_valid), 32'd0);
        end
        for (int i = 0; i < 8; i++)
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        chk("redir_first_addr", first_gnt_addr, 32'h100);
        chk("redir_first_pop", first_pop_pc, 32'h100);

        // Redirect colliding with a response and a pop.
        lat = 1;
        for (int i = 0; i < 6; i++)
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        npops = 0;
        tick(1'b1, 32'h0000_0200, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        chk("collide_valid_next", 32'(seen_valid), 32'd0);
        for (int i = 0; i < 6; i++)
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        chk("collide_first_pop", first_pop_pc, 32'h200);

        // Address wrap at the top of the address space.
        ngrants  = 0;
        npops    = 0;
        saw_zero = 1'b0;
        tick(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++)
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        chk("wrap_first_addr", first_gnt_addr, 32'hFFFF_FFF8);
        chk("wrap_first_pop", first_pop_pc, 32'hFFFF_FFF8);
        chk("wrap_pop_zero", 32'(saw_zero), 32'd1);

        // Reset mid-stream with requests outstanding, then a stray response.
        lat = 3;
        do_reset(2);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        chk("pre_rst_inflight", 32'(ngrants), 32'd2);
        do_reset(1);
        tick(1'b0, 32'h0, 1'b1, 1'b1);
        chk("stray_valid_same", 32'(seen_valid), 32'd0);
        chk("post_rst_addr", first_gnt_addr, RESET_PC);
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        chk("stray_valid_next", 32'(seen_valid), 32'd0);
        for (int i = 0; i < 8; i++)
            tick(1'b0, 32'h0, 1'b1, 1'b0);
        chk("post_rst_first_pop", first_pop_pc, RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
